pll_clk_sequencer: RTL
======================

// Module: pll_clk_sequencer
// PURPOSE
// Supervisor for the GW5A PLL generating the LCD pixel clock (50 MHz ref in, CLKOUT0 = VCO/ODIV0).
// Runs on the free-running 50 MHz reference clock. Sequences PLL power-up and reset, qualifies LOCK,
// gates CLKOUT0 until stable, and reprograms ODIV0 at runtime to switch panel timings.
// Also recovers from loss of lock with bounded retries. Sits between board reset and the screen timing generator.
// PARAMETERS
// RST_CYCLES    64     cycles PLL RESET is held high per attempt (>=1)
// LOCK_STABLE   1024   consecutive locked cycles before CLKOUT0 is enabled
// LOCK_TIMEOUT  65536  max cycles in WAIT_LOCK before the attempt counts as failed
// LOSS_FILT     4      consecutive unlocked cycles in RUN that declare loss of lock
// MAX_RETRY     3      failed attempts tolerated before FAULT
// DIV_DEFAULT   30     ODIV0 divider after reset
// DIV_MIN       2      smallest legal divider; DIV_MAX is fixed at 127
// PORTS
// sys_clk      in   1  50 MHz reference clock
// sys_rst_n    in   1  synchronous, active-low reset
// pll_lock     in   1  PLL LOCK, asynchronous; 2-FF synchronised internally
// pll_reset    out  1  to PLL RESET
// pll_pwd      out  1  to PLL PLLPWD
// pll_enclk0   out  1  to PLL ENCLK0 (CLKOUT0 gate)
// pll_odiv0    out  7  divider value; encoded to the ODSEL0 field by pll_ctrl_pkg::odsel_enc
// cfg_req      in   1  single-cycle request; honoured only when cfg_ready=1, otherwise dropped
// cfg_div      in   7  new divider, sampled with cfg_req
// cfg_ready    out  1  high in RUN and FAULT
// cfg_done     out  1  1-cycle pulse: request finished (success or reject)
// cfg_err      out  1  valid with cfg_done: 1 = rejected (div<DIV_MIN) or ended in FAULT
// clk_ready    out  1  high only in RUN; downstream resets are released from this
// fault        out  1  high in FAULT
// BEHAVIOUR
// - Reset values: pll_reset=1, pll_pwd=0, pll_enclk0=0, pll_odiv0=DIV_DEFAULT. All other outputs 0.
//   State is RST_HOLD, retry count is 0, and div_reg=DIV_DEFAULT.
// - Each state sets its counter to 0 on entry.
// - States:
//   RST_HOLD: pll_reset=1. After RST_CYCLES cycles go to WAIT_LOCK.
//   WAIT_LOCK: pll_reset=0. Synced lock high LOCK_STABLE consecutive cycles -> RUN.
//     Any unlocked cycle restarts the stable count. The timeout counter keeps running and is not restarted.
//     Timeout reached -> retry+1. If retry>MAX_RETRY go to FAULT, otherwise go to RST_HOLD.
//   RUN: pll_enclk0=1 and clk_ready=1, both registered in the cycle RUN is entered.
//     Clear retry. Set cfg_done if a request is pending.
//     LOSS_FILT consecutive unlocked cycles -> GATE with cause=loss.
//     Accepted cfg_req with cfg_div>=DIV_MIN: div_reg<=cfg_div, go to GATE with cause=cfg.
//     cfg_div<DIV_MIN: stay in RUN and pulse cfg_done+cfg_err on the next cycle.
//   GATE: pll_enclk0=0 and clk_ready=0 for 2 cycles, then RST_HOLD. pll_odiv0<=div_reg on GATE exit,
//     so the divider only changes while RESET=1 and the clock is gated.
//   FAULT: pll_reset=1, pll_enclk0=0, fault=1. If a request is pending, pulse cfg_done+cfg_err on entry.
//     cfg_req is accepted here: clear retry, apply the same range check, go to RST_HOLD.
// - Simultaneous loss of lock and cfg_req in RUN: the request wins. It is accepted and follows the same
//   GATE path, and the loss is absorbed by it.
// - Lock glitch shorter than LOSS_FILT in RUN: ignored, no output changes.
// - sys_rst_n low mid-sequence: restart from the reset values. A pending request is lost and gets no cfg_done.
// - pll_pwd stays 0 in every state; it is a port only so the wrapper connects it.
// - Latency: from sys_rst_n release to clk_ready is RST_CYCLES + 2 (lock sync) + T_lock + LOCK_STABLE cycles,
//   where T_lock is the PLL's own lock time.
// STRUCTURE
// - pll_ctrl_pkg: state enum {RST_HOLD,WAIT_LOCK,RUN,GATE,FAULT}, cause enum, odsel_enc() function, DIV_MAX=127.
// - Sub-module pll_lock_filter: 2-FF synchroniser plus consecutive-high and consecutive-low counters.
//   Outputs lock_stable and lock_lost; parameters are LOCK_STABLE and LOSS_FILT.
// - Counter widths come from $clog2 of the largest parameter each counter must reach.
// TESTING (behavioural PLL model: LOCK rises N cycles after RESET falls, with forceable drop)
// 1 Reset release, model N=100, small params (RST 8, STABLE 16) -> clk_ready rises at cycle 8+2+100+16 (±1), odiv0=30.
// 2 cfg_req div=20 in RUN -> enclk0=0 for 2 cycles, reset pulse 8 cycles with odiv0=20,
//   clk_ready returns, then cfg_done=1 with cfg_err=0.
// 3 cfg_req div=1 -> one cycle later cfg_done=1 and cfg_err=1. No reset pulse, clk_ready stays 1.
// 4 Lock drop 3 cycles (LOSS_FILT 4) -> no change. Lock drop 4 cycles -> GATE then resequence, no cfg_done.
// 5 Model never locks, TIMEOUT 256, MAX_RETRY 3 -> 4 reset pulses, then fault=1 and pll_reset=1.
//   Then cfg_req div=30 with a locking model -> clk_ready=1.
// 6 sys_rst_n low 1 cycle during WAIT_LOCK after a cfg_req -> all reset values.
//   Sequence restarts with odiv0=30 and no cfg_done.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL clock sequencer.
package pll_ctrl_pkg;

  localparam int DIV_W   = 7;
  localparam int DIV_MAX = 127;

  typedef enum logic [2:0] {
    RST_HOLD  = 3'd0,
    WAIT_LOCK = 3'd1,
    RUN       = 3'd2,
    GATE      = 3'd3,
    FAULT     = 3'd4
  } pll_state_e;

  // Why the sequencer is currently walking the GATE/RST_HOLD/WAIT_LOCK path.
  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_LOSS = 2'd1,
    CAUSE_CFG  = 2'd2
  } pll_cause_e;

  // ODSEL0 holds the divider as (128 - div) in 7 bits; used by the PLL wrapper.
  function automatic logic [DIV_W-1:0] odsel_enc(input logic [DIV_W-1:0] div);
    logic [DIV_W:0] full;
    full = 8'd128 - {1'b0, div};
    return full[DIV_W-1:0];
  endfunction

endpackage

// File: rtl/pll_clk_sequencer_if.sv
// Runtime divider reconfiguration port.
//
// Handshake: cfg_req is a single-cycle request with cfg_div sampled alongside it.
// It is accepted only in a cycle where cfg_ready is high; otherwise it is dropped
// and never answered. Every accepted request is answered by exactly one cfg_done
// pulse, with cfg_err qualifying it (1 = rejected or ended in FAULT), unless a
// system reset intervenes, in which case the request is lost silently.
interface pll_clk_sequencer_if;
  logic       cfg_req;
  logic [6:0] cfg_div;
  logic       cfg_ready;
  logic       cfg_done;
  logic       cfg_err;

  modport master (output cfg_req, cfg_div, input cfg_ready, cfg_done, cfg_err);
  modport slave  (input cfg_req, cfg_div, output cfg_ready, cfg_done, cfg_err);
endinterface

// File: rtl/pll_lock_filter.sv
// Synchronises the asynchronous PLL LOCK and qualifies it with run-length counters:
// lock_stable_o after LOCK_STABLE consecutive high samples, lock_lost_o after
// LOSS_FILT consecutive low samples. clr_i restarts both counts.
module pll_lock_filter #(
  parameter int LOCK_STABLE = 1024,
  parameter int LOSS_FILT   = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic lock_async_i,
  input  logic clr_i,
  output logic lock_stable_o,
  output logic lock_lost_o
);
  localparam int HI_W = $clog2(LOCK_STABLE + 1);
  localparam int LO_W = $clog2(LOSS_FILT + 1);

  logic [1:0]      sync_q;
  logic [HI_W-1:0] hi_q, hi_d;
  logic [LO_W-1:0] lo_q, lo_d;

  // Saturating run-length counts of the synchronised lock level.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (clr_i) begin
      hi_d = '0;
      lo_d = '0;
    end else if (sync_q[1]) begin
      lo_d = '0;
      if (hi_q != HI_W'(LOCK_STABLE)) hi_d = hi_q + 1'b1;
    end else begin
      hi_d = '0;
      if (lo_q != LO_W'(LOSS_FILT)) lo_d = lo_q + 1'b1;
    end
  end

  // Two-flop synchroniser and counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], lock_async_i};
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign lock_stable_o = (hi_q == HI_W'(LOCK_STABLE));
  assign lock_lost_o   = (lo_q == LO_W'(LOSS_FILT));
endmodule

// File: rtl/pll_clk_sequencer.sv
// PLL supervisor: sequences RESET, qualifies LOCK, gates CLKOUT0 and applies new
// ODIV0 values only while the PLL is held in reset with its output gated.
module pll_clk_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES   = 64,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int LOSS_FILT    = 4,
  parameter int MAX_RETRY    = 3,
  parameter int DIV_DEFAULT  = 30,
  parameter int DIV_MIN      = 2
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               pll_lock,
  output logic               pll_reset,
  output logic               pll_pwd,
  output logic               pll_enclk0,
  output logic [DIV_W-1:0]   pll_odiv0,
  output logic               clk_ready,
  output logic               fault,
  output pll_state_e         dbg_state_o,
  pll_clk_sequencer_if.slave cfg
);
  localparam int CNT_MAX = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RTY_W   = $clog2(MAX_RETRY + 2);

  pll_state_e       state_q, state_d;
  pll_cause_e       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [DIV_W-1:0] div_q, div_d, odiv_q, odiv_d;
  logic             reset_q, enclk_q, ready_q, cfg_ready_q, fault_q, done_q, err_q;
  logic             done_d, err_d;
  logic             lock_stable, lock_lost, accept, div_ok, state_chg;

  assign accept    = cfg.cfg_req && cfg_ready_q;
  assign div_ok    = (cfg.cfg_div >= DIV_W'(DIV_MIN));
  assign state_chg = (state_d != state_q);

  pll_lock_filter #(
    .LOCK_STABLE (LOCK_STABLE),
    .LOSS_FILT   (LOSS_FILT)
  ) u_lock_filter (
    .clk_i         (sys_clk),
    .rst_ni        (sys_rst_n),
    .lock_async_i  (pll_lock),
    .clr_i         (state_chg),
    .lock_stable_o (lock_stable),
    .lock_lost_o   (lock_lost)
  );

  // Next-state, counters, retry bookkeeping and cfg completion.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    div_d   = div_q;
    odiv_d  = odiv_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      RST_HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        cnt_d = cnt_q + 1'b1;
        if (lock_stable) begin
          state_d = RUN;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          retry_d = retry_q + 1'b1;
          state_d = (retry_d > RTY_W'(MAX_RETRY)) ? FAULT : RST_HOLD;
        end
      end
      RUN: begin
        retry_d = '0;
        // A request in the same cycle as a loss wins; the loss rides its GATE path.
        if (accept) begin
          if (div_ok) begin
            div_d   = cfg.cfg_div;
            cause_d = CAUSE_CFG;
            state_d = GATE;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end else if (lock_lost) begin
          cause_d = CAUSE_LOSS;
          state_d = GATE;
        end
      end
      GATE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = RST_HOLD;
          odiv_d  = div_q;
        end
      end
      FAULT: begin
        if (accept) begin
          if (div_ok) begin
            div_d   = cfg.cfg_div;
            odiv_d  = cfg.cfg_div;  // RESET already high and clock gated here
            retry_d = '0;
            cause_d = CAUSE_CFG;
            state_d = RST_HOLD;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      default: state_d = RST_HOLD;
    endcase
    if (state_chg) cnt_d = '0;
    // Close out a pending request when the resequence lands in RUN or FAULT.
    if (state_chg && (state_d == RUN)) begin
      cause_d = CAUSE_NONE;
      if (cause_q == CAUSE_CFG) done_d = 1'b1;
    end
    if (state_chg && (state_d == FAULT)) begin
      cause_d = CAUSE_NONE;
      if (cause_q == CAUSE_CFG) begin
        done_d = 1'b1;
        err_d  = 1'b1;
      end
    end
  end

  // State and output registers; outputs are decoded from the next state so they
  // change on the same edge the state is entered.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= RST_HOLD;
      cause_q     <= CAUSE_NONE;
      cnt_q       <= '0;
      retry_q     <= '0;
      div_q       <= DIV_W'(DIV_DEFAULT);
      odiv_q      <= DIV_W'(DIV_DEFAULT);
      reset_q     <= 1'b1;
      enclk_q     <= 1'b0;
      ready_q     <= 1'b0;
      cfg_ready_q <= 1'b0;
      fault_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      div_q       <= div_d;
      odiv_q      <= odiv_d;
      reset_q     <= (state_d == RST_HOLD) || (state_d == FAULT);
      enclk_q     <= (state_d == RUN);
      ready_q     <= (state_d == RUN);
      cfg_ready_q <= (state_d == RUN) || (state_d == FAULT);
      fault_q     <= (state_d == FAULT);
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign pll_reset     = reset_q;
  assign pll_pwd       = 1'b0;
  assign pll_enclk0    = enclk_q;
  assign pll_odiv0     = odiv_q;
  assign clk_ready     = ready_q;
  assign fault         = fault_q;
  assign dbg_state_o   = state_q;
  assign cfg.cfg_ready = cfg_ready_q;
  assign cfg.cfg_done  = done_q;
  assign cfg.cfg_err   = err_q;
endmodule
